// File: rtl/maxpool_sched_pkg.sv
// Shared types and helpers for the max-pooling frame scheduler.
package maxpool_sched_pkg;

   localparam int unsigned DefaultDataW = 48;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Bits needed to count 0..v-1, never less than one.
   function automatic int unsigned clog2_min1(input int unsigned v);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(v)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/maxpool_win_cnt.sv
// Raster position tracker: column/row counters plus window-phase and output-column counters,
// with in-range, window-first, window-end and last-pixel flags.
module maxpool_win_cnt
   import maxpool_sched_pkg::*;
#(
   parameter int unsigned FM_SIZE     = 4,
   parameter int unsigned KERNEL_SIZE = 2,
   localparam int unsigned OcW        = clog2_min1(FM_SIZE / KERNEL_SIZE)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           clear_i,
   input  logic           advance_i,
   output logic [OcW-1:0] oc_o,
   output logic           in_range_o,
   output logic           win_first_o,
   output logic           win_end_o,
   output logic           last_o
);

   localparam int unsigned OutSize = FM_SIZE / KERNEL_SIZE;
   localparam int unsigned CW      = clog2_min1(FM_SIZE);
   localparam int unsigned KW      = clog2_min1(KERNEL_SIZE);

   localparam logic [CW-1:0]  PosMax = CW'(FM_SIZE - 1);
   localparam logic [KW-1:0]  KMax   = KW'(KERNEL_SIZE - 1);
   localparam logic [OcW-1:0] OcMax  = OcW'(OutSize - 1);

   logic [CW-1:0]  c_q, c_d, r_q, r_d;
   logic [KW-1:0]  kc_q, kc_d, kr_q, kr_d;
   logic [OcW-1:0] oc_q, oc_d, orow_q, orow_d;
   logic           col_ok_q, col_ok_d, row_ok_q, row_ok_d;

   // The *_ok flags drop once the last full window in that dimension has been passed.
   always_comb begin
      c_d      = c_q;
      kc_d     = kc_q;
      oc_d     = oc_q;
      col_ok_d = col_ok_q;
      r_d      = r_q;
      kr_d     = kr_q;
      orow_d   = orow_q;
      row_ok_d = row_ok_q;
      if (clear_i) begin
         c_d      = '0;
         kc_d     = '0;
         oc_d     = '0;
         col_ok_d = 1'b1;
         r_d      = '0;
         kr_d     = '0;
         orow_d   = '0;
         row_ok_d = 1'b1;
      end else if (advance_i) begin
         if (c_q == PosMax) begin
            c_d      = '0;
            kc_d     = '0;
            oc_d     = '0;
            col_ok_d = 1'b1;
            if (r_q == PosMax) begin
               r_d      = '0;
               kr_d     = '0;
               orow_d   = '0;
               row_ok_d = 1'b1;
            end else begin
               r_d = r_q + 1'b1;
               if (kr_q == KMax) begin
                  kr_d = '0;
                  if (orow_q == OcMax) begin
                     row_ok_d = 1'b0;
                  end else begin
                     orow_d = orow_q + 1'b1;
                  end
               end else begin
                  kr_d = kr_q + 1'b1;
               end
            end
         end else begin
            c_d = c_q + 1'b1;
            if (kc_q == KMax) begin
               kc_d = '0;
               if (oc_q == OcMax) begin
                  col_ok_d = 1'b0;
               end else begin
                  oc_d = oc_q + 1'b1;
               end
            end else begin
               kc_d = kc_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         c_q      <= '0;
         kc_q     <= '0;
         oc_q     <= '0;
         col_ok_q <= 1'b1;
         r_q      <= '0;
         kr_q     <= '0;
         orow_q   <= '0;
         row_ok_q <= 1'b1;
      end else begin
         c_q      <= c_d;
         kc_q     <= kc_d;
         oc_q     <= oc_d;
         col_ok_q <= col_ok_d;
         r_q      <= r_d;
         kr_q     <= kr_d;
         orow_q   <= orow_d;
         row_ok_q <= row_ok_d;
      end
   end

   assign oc_o        = oc_q;
   assign in_range_o  = col_ok_q && row_ok_q;
   assign win_first_o = (kc_q == '0) && (kr_q == '0);
   assign win_end_o   = (kc_q == KMax) && (kr_q == KMax);
   assign last_o      = (c_q == PosMax) && (r_q == PosMax);

endmodule

// File: rtl/maxpool_sched.sv
// Frame scheduler for non-overlapping max pooling of a raster-order signed sample stream;
// keeps one partial max per output column and emits window maxima on a valid/ready port.
module maxpool_sched
   import maxpool_sched_pkg::*;
#(
   parameter int unsigned KERNEL_SIZE = 2,
   parameter int unsigned FM_SIZE     = 4,
   parameter int unsigned STRIDE      = 2,
   parameter int unsigned DATA_W      = DefaultDataW
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic signed [DATA_W-1:0] i_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic signed [DATA_W-1:0] o_data,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam int unsigned OutSize = FM_SIZE / KERNEL_SIZE;
   localparam int unsigned OcW     = clog2_min1(OutSize);

   if (STRIDE != KERNEL_SIZE) begin : gen_bad_stride
      $error("maxpool_sched: STRIDE must equal KERNEL_SIZE");
   end
   if (FM_SIZE < KERNEL_SIZE || KERNEL_SIZE == 0) begin : gen_bad_size
      $error("maxpool_sched: FM_SIZE must be >= KERNEL_SIZE > 0");
   end

   state_e state_q, state_d;

   logic signed [DATA_W-1:0] pmax_q [OutSize];
   logic signed [DATA_W-1:0] data_q, cur, nv;
   logic                     valid_q;

   logic           cnt_clear, accept, load;
   logic [OcW-1:0] oc;
   logic           in_range, win_first, win_end, last_px;

   maxpool_win_cnt #(
      .FM_SIZE     (FM_SIZE),
      .KERNEL_SIZE (KERNEL_SIZE)
   ) u_win_cnt (
      .clk_i       (i_clk),
      .rst_ni      (i_rst_n),
      .clear_i     (cnt_clear),
      .advance_i   (accept),
      .oc_o        (oc),
      .in_range_o  (in_range),
      .win_first_o (win_first),
      .win_end_o   (win_end),
      .last_o      (last_px)
   );

   always_comb begin
      o_ready   = (state_q == StRun) && (!valid_q || i_ready);
      accept    = i_valid && o_ready;
      cur       = pmax_q[oc];
      // First sample of a window restarts the partial max for its column.
      nv        = (win_first || (i_data > cur)) ? i_data : cur;
      load      = accept && in_range && win_end;
      state_d   = state_q;
      cnt_clear = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d   = StRun;
               cnt_clear = 1'b1;
            end
         end
         StRun: begin
            if (accept && last_px) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!valid_q || i_ready) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (accept && in_range) begin
         pmax_q[oc] <= nv;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            valid_q <= 1'b1;
            data_q  <= nv;
         end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_busy  = (state_q == StRun) || (state_q == StDrain);
   assign o_done  = (state_q == StDone);

endmodule

// File: tb/tb_maxpool_sched.sv
// Self-checking bench for maxpool_sched: N=4 and N=5 instances, directed and random frames
// checked against a window-max reference model.
module tb_maxpool_sched;

   localparam int K = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic start4, start5, valid;
   logic signed [47:0] data;
   logic rdy = 1'b1;

   logic ready4, ov4, busy4, done4, ready5, ov5, busy5, done5;
   logic signed [47:0] od4, od5;

   logic sel5 = 1'b0;
   wire ready_s = sel5 ? ready5 : ready4;
   wire ov_s    = sel5 ? ov5 : ov4;
   wire busy_s  = sel5 ? busy5 : busy4;
   wire signed [47:0] od_s = sel5 ? od5 : od4;

   int tests = 0, fails = 0;
   int done4_cnt = 0, done5_cnt = 0, base4 = 0, base5 = 0;
   int hs_count = 0, hs_ref = 0, stall_cnt = 0;
   bit stall_mode = 1'b0, prev_stall = 1'b0;
   logic signed [47:0] prev_data;
   logic signed [47:0] exp_q[$];
   logic signed [47:0] frame[25];
   int n_fm = 4, kidx = 0;

   maxpool_sched #(.KERNEL_SIZE(2), .FM_SIZE(4), .STRIDE(2), .DATA_W(48)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_valid(valid), .o_ready(ready4),
      .i_data(data), .o_valid(ov4), .i_ready(rdy), .o_data(od4), .o_busy(busy4), .o_done(done4)
   );

   maxpool_sched #(.KERNEL_SIZE(2), .FM_SIZE(5), .STRIDE(2), .DATA_W(48)) u_dut5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start5), .i_valid(valid), .o_ready(ready5),
      .i_data(data), .o_valid(ov5), .i_ready(rdy), .o_data(od5), .o_busy(busy5), .o_done(done5)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   // Output monitor: scoreboard pop on handshake, hold-while-stalled, o_done counting.
   always @(negedge clk) begin
      if (done4) done4_cnt++;
      if (done5) done5_cnt++;
      if (prev_stall) begin
         check("hold_valid", 64'(ov_s), 64'd1);
         check("hold_data", od_s, prev_data);
      end
      if (ov_s && rdy) begin
         hs_count++;
         check("out_pending", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) check("out_data", od_s, exp_q.pop_front());
      end
      if (ov_s && !rdy) check("ready_stalled", 64'(ready_s), 64'd0);
      prev_stall = ov_s && !rdy && rst_n;
      prev_data  = od_s;
   end

   // Downstream: when stalling is enabled, hold i_ready low 5 cycles per new pooled sample.
   always @(posedge clk) begin
      #1;
      if (hs_count != hs_ref) begin
         hs_ref    = hs_count;
         stall_cnt = 0;
      end
      if (stall_mode && ov_s && stall_cnt < 5) begin
         rdy = 1'b0;
         stall_cnt++;
      end else begin
         rdy = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: record the frame and, when a full KxK window closes, queue its max.
   task automatic model_push(input logic signed [47:0] d);
      int r, c, o;
      logic signed [47:0] m;
      r = kidx / n_fm;
      c = kidx % n_fm;
      o = n_fm / K;
      frame[kidx] = d;
      if (r % K == K - 1 && c % K == K - 1 && r < o * K && c < o * K) begin
         m = frame[(r - K + 1) * n_fm + (c - K + 1)];
         for (int dr = 0; dr < K; dr++)
            for (int dc = 0; dc < K; dc++)
               if (frame[(r - dr) * n_fm + (c - dc)] > m) m = frame[(r - dr) * n_fm + (c - dc)];
         exp_q.push_back(m);
      end
      kidx++;
   endtask

   task automatic send(input logic signed [47:0] d, input int gap);
      bit acc;
      int n;
      repeat (gap) step();
      model_push(d);
      valid = 1'b1;
      data  = d;
      acc   = 1'b0;
      n     = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = ready_s;
         step();
         n++;
      end
      valid = 1'b0;
      if (!acc) check("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic start_frame(input bit s5, input int n);
      sel5  = s5;
      n_fm  = n;
      kidx  = 0;
      base4 = done4_cnt;
      base5 = done5_cnt;
      if (s5) start5 = 1'b1;
      else start4 = 1'b1;
      step();
      start4 = 1'b0;
      start5 = 1'b0;
      check("busy_after_start", 64'(busy_s), 64'd1);
   endtask

   task automatic finish_frame(input string tag);
      int n;
      n = 0;
      while ((sel5 ? done5_cnt - base5 : done4_cnt - base4) == 0 && n < 200) begin
         step();
         n++;
      end
      repeat (4) step();
      check({tag, "_done_once"}, sel5 ? done5_cnt - base5 : done4_cnt - base4, 1);
      check({tag, "_done_other"}, sel5 ? done4_cnt - base4 : done5_cnt - base5, 0);
      check({tag, "_busy_idle"}, 64'(busy_s), 64'd0);
      check({tag, "_all_out"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [63:0] rw;
      rst_n  = 1'b0;
      start4 = 1'b0;
      start5 = 1'b0;
      valid  = 1'b1;
      data   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid4", 64'(ov4), 0);   check("rst_valid5", 64'(ov5), 0);
      check("rst_data4", od4, 0);         check("rst_data5", od5, 0);
      check("rst_busy4", 64'(busy4), 0);  check("rst_busy5", 64'(busy5), 0);
      check("rst_done4", 64'(done4), 0);  check("rst_done5", 64'(done5), 0);
      check("rst_ready4", 64'(ready4), 0); check("rst_ready5", 64'(ready5), 0);
      step();
      valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) step();

      // Ascending raster 0..15.
      start_frame(0, 4);
      for (int k = 0; k < 16; k++) send(48'(k), 0);
      finish_frame("t1");

      // All-negative frame including the most negative value.
      start_frame(0, 4);
      for (int k = 0; k < 16; k++) send((k == 15) ? 48'sh8000_0000_0000 : -48'(k + 1), 0);
      finish_frame("t2");

      // Downstream stalls on every pooled sample.
      stall_mode = 1'b1;
      start_frame(0, 4);
      for (int k = 0; k < 16; k++) send(48'(k), 0);
      finish_frame("t3");
      stall_mode = 1'b0;

      // N=5: trailing row and column consumed without output.
      start_frame(1, 5);
      for (int k = 0; k < 25; k++) send(48'(k), 0);
      finish_frame("t4");

      // Reset mid-frame abandons it; next frame is clean.
      start_frame(0, 4);
      for (int k = 0; k < 7; k++) send(48'(k), 0);
      rst_n = 1'b0;
      valid = 1'b1;
      @(negedge clk);
      check("midrst_valid", 64'(ov4), 0);
      check("midrst_data", od4, 0);
      check("midrst_busy", 64'(busy4), 0);
      check("midrst_ready", 64'(ready4), 0);
      step();
      valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) step();
      check("midrst_no_done", done4_cnt - base4, 0);
      check("midrst_no_pending", exp_q.size(), 0);
      start_frame(0, 4);
      for (int k = 0; k < 16; k++) send(48'(k), 0);
      finish_frame("t5");

      // i_valid in IDLE is refused; i_start in RUN and DRAIN is ignored.
      valid = 1'b1;
      data  = 48'd99;
      repeat (2) step();
      @(negedge clk);
      check("idle_ready4", 64'(ready4), 0);
      check("idle_ready5", 64'(ready5), 0);
      step();
      valid = 1'b0;
      start_frame(0, 4);
      for (int k = 0; k < 16; k++) begin
         start4 = (k == 6);
         send(48'(100 - k), 0);
         start4 = 1'b0;
      end
      check("drain_busy", 64'(busy4), 1);
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      finish_frame("t6");
      repeat (5) step();
      check("t6_stays_idle", 64'(busy4), 0);
      check("t6_no_extra_done", done4_cnt - base4, 1);

      // Random frames on both sizes, random gaps and stalls.
      for (int f = 0; f < 6; f++) begin
         stall_mode = 1'($urandom_range(0, 1));
         start_frame(1'(f % 2), (f % 2 == 1) ? 5 : 4);
         for (int k = 0; k < n_fm * n_fm; k++) begin
            rw = {$urandom(), $urandom()};
            send(rw[47:0], int'($urandom_range(0, 2)));
         end
         finish_frame("rand");
      end
      stall_mode = 1'b0;

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
